// File: rtl/axi_lite_pkg.sv
// Shared widths, AXI response codes and FSM encodings for the two-master AXI4-Lite arbiter.
package axi_lite_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 32;
    localparam int unsigned DATA_W_DEFAULT = 32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way grant: a lone requester wins; on a tie the master other than i_ptr wins,
// or master 1 always wins when FIXED_PRIO is set.
module rr_arb2 #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic [1:0] i_req,
    input  logic       i_ptr,
    output logic       o_gnt_valid,
    output logic       o_gnt
);

    logic w_tie_winner;

    assign w_tie_winner = FIXED_PRIO ? 1'b1 : ~i_ptr;
    assign o_gnt_valid  = |i_req;

    always_comb begin
        o_gnt = 1'b0;
        case (i_req)
            2'b01:   o_gnt = 1'b0;
            2'b10:   o_gnt = 1'b1;
            2'b11:   o_gnt = w_tie_winner;
            default: o_gnt = 1'b0;
        endcase
    end

endmodule

// File: rtl/axi_lite_arb2.sv
// Two-master to one-slave AXI4-Lite arbiter with independent read and write channels.
// Define AXI_ARB_FIXED_PRIO_EN to make master 1 win every tie instead of round-robin.
module axi_lite_arb2
    import axi_lite_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    // master 0 (instruction fetch)
    input  logic [ADDR_W-1:0]     m0_araddr,
    input  logic                  m0_arvalid,
    output logic                  m0_arready,
    output logic [DATA_W-1:0]     m0_rdata,
    output logic [1:0]            m0_rresp,
    output logic                  m0_rvalid,
    input  logic                  m0_rready,
    input  logic [ADDR_W-1:0]     m0_awaddr,
    input  logic                  m0_awvalid,
    output logic                  m0_awready,
    input  logic [DATA_W-1:0]     m0_wdata,
    input  logic [DATA_W/8-1:0]   m0_wstrb,
    input  logic                  m0_wvalid,
    output logic                  m0_wready,
    output logic [1:0]            m0_bresp,
    output logic                  m0_bvalid,
    input  logic                  m0_bready,
    // master 1 (load/store)
    input  logic [ADDR_W-1:0]     m1_araddr,
    input  logic                  m1_arvalid,
    output logic                  m1_arready,
    output logic [DATA_W-1:0]     m1_rdata,
    output logic [1:0]            m1_rresp,
    output logic                  m1_rvalid,
    input  logic                  m1_rready,
    input  logic [ADDR_W-1:0]     m1_awaddr,
    input  logic                  m1_awvalid,
    output logic                  m1_awready,
    input  logic [DATA_W-1:0]     m1_wdata,
    input  logic [DATA_W/8-1:0]   m1_wstrb,
    input  logic                  m1_wvalid,
    output logic                  m1_wready,
    output logic [1:0]            m1_bresp,
    output logic                  m1_bvalid,
    input  logic                  m1_bready,
    // slave side
    output logic [ADDR_W-1:0]     s_araddr,
    output logic                  s_arvalid,
    input  logic                  s_arready,
    input  logic [DATA_W-1:0]     s_rdata,
    input  logic [1:0]            s_rresp,
    input  logic                  s_rvalid,
    output logic                  s_rready,
    output logic [ADDR_W-1:0]     s_awaddr,
    output logic                  s_awvalid,
    input  logic                  s_awready,
    output logic [DATA_W-1:0]     s_wdata,
    output logic [DATA_W/8-1:0]   s_wstrb,
    output logic                  s_wvalid,
    input  logic                  s_wready,
    input  logic [1:0]            s_bresp,
    input  logic                  s_bvalid,
    output logic                  s_bready
);

`ifdef AXI_ARB_FIXED_PRIO_EN
    localparam bit FIXED_PRIO = 1'b1;
`else
    localparam bit FIXED_PRIO = 1'b0;
`endif

    rd_state_e r_rd_state, w_rd_state_next;
    logic      r_rd_gnt, w_rd_gnt_next;
    logic      r_rd_ptr, w_rd_ptr_next;
    wr_state_e r_wr_state, w_wr_state_next;
    logic      r_wr_gnt, w_wr_gnt_next;
    logic      r_wr_ptr, w_wr_ptr_next;
    logic      r_aw_done, w_aw_done_next;
    logic      r_w_done, w_w_done_next;

    logic                w_rd_req_any, w_rd_arb_gnt;
    logic                w_wr_req_any, w_wr_arb_gnt;
    logic [ADDR_W-1:0]   w_rd_araddr, w_wr_awaddr;
    logic                w_rd_arvalid, w_rd_rready;
    logic                w_wr_awvalid, w_wr_wvalid, w_wr_bready;
    logic [DATA_W-1:0]   w_wr_wdata;
    logic [DATA_W/8-1:0] w_wr_wstrb;
    logic                w_aw_hs, w_w_hs;

    rr_arb2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_rd_arb (
        .i_req       ({m1_arvalid, m0_arvalid}),
        .i_ptr       (r_rd_ptr),
        .o_gnt_valid (w_rd_req_any),
        .o_gnt       (w_rd_arb_gnt)
    );

    // Write grant is triggered by AW alone; a W beat cannot open a transaction.
    rr_arb2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_wr_arb (
        .i_req       ({m1_awvalid, m0_awvalid}),
        .i_ptr       (r_wr_ptr),
        .o_gnt_valid (w_wr_req_any),
        .o_gnt       (w_wr_arb_gnt)
    );

    assign w_rd_araddr  = r_rd_gnt ? m1_araddr  : m0_araddr;
    assign w_rd_arvalid = r_rd_gnt ? m1_arvalid : m0_arvalid;
    assign w_rd_rready  = r_rd_gnt ? m1_rready  : m0_rready;
    assign w_wr_awaddr  = r_wr_gnt ? m1_awaddr  : m0_awaddr;
    assign w_wr_awvalid = r_wr_gnt ? m1_awvalid : m0_awvalid;
    assign w_wr_wdata   = r_wr_gnt ? m1_wdata   : m0_wdata;
    assign w_wr_wstrb   = r_wr_gnt ? m1_wstrb   : m0_wstrb;
    assign w_wr_wvalid  = r_wr_gnt ? m1_wvalid  : m0_wvalid;
    assign w_wr_bready  = r_wr_gnt ? m1_bready  : m0_bready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_state <= R_IDLE;
            r_rd_gnt   <= 1'b0;
            r_rd_ptr   <= 1'b1;
            r_wr_state <= W_IDLE;
            r_wr_gnt   <= 1'b0;
            r_wr_ptr   <= 1'b1;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
        end else begin
            r_rd_state <= w_rd_state_next;
            r_rd_gnt   <= w_rd_gnt_next;
            r_rd_ptr   <= w_rd_ptr_next;
            r_wr_state <= w_wr_state_next;
            r_wr_gnt   <= w_wr_gnt_next;
            r_wr_ptr   <= w_wr_ptr_next;
            r_aw_done  <= w_aw_done_next;
            r_w_done   <= w_w_done_next;
        end
    end

    always_comb begin
        w_rd_state_next = r_rd_state;
        w_rd_gnt_next   = r_rd_gnt;
        w_rd_ptr_next   = r_rd_ptr;
        s_araddr        = '0;
        s_arvalid       = 1'b0;
        s_rready        = 1'b0;
        m0_arready      = 1'b0;
        m1_arready      = 1'b0;
        m0_rdata        = '0;
        m1_rdata        = '0;
        m0_rresp        = 2'b00;
        m1_rresp        = 2'b00;
        m0_rvalid       = 1'b0;
        m1_rvalid       = 1'b0;
        case (r_rd_state)
            R_IDLE: begin
                if (w_rd_req_any) begin
                    w_rd_gnt_next   = w_rd_arb_gnt;
                    w_rd_state_next = R_ADDR;
                end
            end
            R_ADDR: begin
                s_araddr  = w_rd_araddr;
                s_arvalid = w_rd_arvalid;
                if (r_rd_gnt) m1_arready = s_arready;
                else          m0_arready = s_arready;
                if (w_rd_arvalid && s_arready) w_rd_state_next = R_DATA;
            end
            R_DATA: begin
                m0_rdata = s_rdata;
                m1_rdata = s_rdata;
                m0_rresp = s_rresp;
                m1_rresp = s_rresp;
                s_rready = w_rd_rready;
                if (r_rd_gnt) m1_rvalid = s_rvalid;
                else          m0_rvalid = s_rvalid;
                if (s_rvalid && w_rd_rready) begin
                    w_rd_state_next = R_IDLE;
                    w_rd_ptr_next   = r_rd_gnt;
                end
            end
            default: w_rd_state_next = R_IDLE;
        endcase
    end

    assign w_aw_hs = (r_wr_state == W_ADDR) && w_wr_awvalid && !r_aw_done && s_awready;
    assign w_w_hs  = (r_wr_state == W_ADDR) && w_wr_wvalid && !r_w_done && s_wready;

    always_comb begin
        w_wr_state_next = r_wr_state;
        w_wr_gnt_next   = r_wr_gnt;
        w_wr_ptr_next   = r_wr_ptr;
        w_aw_done_next  = r_aw_done;
        w_w_done_next   = r_w_done;
        s_awaddr        = '0;
        s_awvalid       = 1'b0;
        s_wdata         = '0;
        s_wstrb         = '0;
        s_wvalid        = 1'b0;
        s_bready        = 1'b0;
        m0_awready      = 1'b0;
        m1_awready      = 1'b0;
        m0_wready       = 1'b0;
        m1_wready       = 1'b0;
        m0_bresp        = 2'b00;
        m1_bresp        = 2'b00;
        m0_bvalid       = 1'b0;
        m1_bvalid       = 1'b0;
        case (r_wr_state)
            W_IDLE: begin
                if (w_wr_req_any) begin
                    w_wr_gnt_next   = w_wr_arb_gnt;
                    w_wr_state_next = W_ADDR;
                end
            end
            W_ADDR: begin
                s_awaddr  = w_wr_awaddr;
                s_awvalid = w_wr_awvalid && !r_aw_done;
                s_wdata   = w_wr_wdata;
                s_wstrb   = w_wr_wstrb;
                s_wvalid  = w_wr_wvalid && !r_w_done;
                if (r_wr_gnt) begin
                    m1_awready = s_awready && !r_aw_done;
                    m1_wready  = s_wready && !r_w_done;
                end else begin
                    m0_awready = s_awready && !r_aw_done;
                    m0_wready  = s_wready && !r_w_done;
                end
                w_aw_done_next = r_aw_done || w_aw_hs;
                w_w_done_next  = r_w_done || w_w_hs;
                // AW and W may complete in either order or together.
                if (w_aw_done_next && w_w_done_next) begin
                    w_wr_state_next = W_RESP;
                    w_aw_done_next  = 1'b0;
                    w_w_done_next   = 1'b0;
                end
            end
            W_RESP: begin
                m0_bresp = s_bresp;
                m1_bresp = s_bresp;
                s_bready = w_wr_bready;
                if (r_wr_gnt) m1_bvalid = s_bvalid;
                else          m0_bvalid = s_bvalid;
                if (s_bvalid && w_wr_bready) begin
                    w_wr_state_next = W_IDLE;
                    w_wr_ptr_next   = r_wr_gnt;
                end
            end
            default: w_wr_state_next = W_IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_lite_arb2.sv
// Directed self-checking bench for axi_lite_arb2; honours AXI_ARB_FIXED_PRIO_EN for tie order.
module tb_axi_lite_arb2;
    import axi_lite_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] m0_araddr, m1_araddr, m0_awaddr, m1_awaddr, m0_wdata, m1_wdata;
    logic [31:0] m0_rdata, m1_rdata, s_araddr, s_rdata, s_awaddr, s_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb, s_wstrb;
    logic [1:0]  m0_rresp, m1_rresp, m0_bresp, m1_bresp, s_rresp, s_bresp;
    logic m0_arvalid, m0_arready, m0_rvalid, m0_rready, m0_awvalid, m0_awready;
    logic m0_wvalid, m0_wready, m0_bvalid, m0_bready;
    logic m1_arvalid, m1_arready, m1_rvalid, m1_rready, m1_awvalid, m1_awready;
    logic m1_wvalid, m1_wready, m1_bvalid, m1_bready;
    logic s_arvalid, s_arready, s_rvalid, s_rready, s_awvalid, s_awready;
    logic s_wvalid, s_wready, s_bvalid, s_bready;

    logic [14:0] hs_vec;
    assign hs_vec = {s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready, m0_arready, m1_arready,
                     m0_rvalid, m1_rvalid, m0_awready, m1_awready, m0_wready, m1_wready,
                     m0_bvalid, m1_bvalid};

    int unsigned n_cmp = 0;
    int unsigned n_fail = 0;

    axi_lite_arb2 #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m0_awaddr(m0_awaddr), .m0_awvalid(m0_awvalid), .m0_awready(m0_awready),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wvalid(m0_wvalid), .m0_wready(m0_wready),
        .m0_bresp(m0_bresp), .m0_bvalid(m0_bvalid), .m0_bready(m0_bready),
        .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
        .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
        .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        {m0_araddr, m1_araddr, m0_awaddr, m1_awaddr, m0_wdata, m1_wdata, s_rdata} = '0;
        {m0_wstrb, m1_wstrb, s_rresp, s_bresp} = '0;
        {m0_arvalid, m0_rready, m0_awvalid, m0_wvalid, m0_bready} = '0;
        {m1_arvalid, m1_rready, m1_awvalid, m1_wvalid, m1_bready} = '0;
        {s_arready, s_rvalid, s_awready, s_wready, s_bvalid} = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        s_rvalid = 1'b1; s_rdata = 32'hA5A5_A5A5; s_bvalid = 1'b1; s_bresp = RESP_SLVERR;
        s_arready = 1'b1; s_awready = 1'b1; s_wready = 1'b1; m0_rready = 1'b1; m1_bready = 1'b1;
        rst = 1'b1;
        step();
        step();
        n_cmp++; if (hs_vec !== 15'h0) begin n_fail++; $display("FAIL reset_hs: got %h want 0", hs_vec); end
        n_cmp++; if (m0_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", m0_rdata); end
        n_cmp++; if (m1_bresp !== 2'b00) begin n_fail++; $display("FAIL reset_bresp: got %h want 0", m1_bresp); end
        rst = 1'b0;
        step();
        n_cmp++; if (hs_vec !== 15'h0) begin n_fail++; $display("FAIL idle_hs: got %h want 0", hs_vec); end
        n_cmp++; if ({s_araddr, s_awaddr, s_wdata} !== 96'h0) begin n_fail++; $display("FAIL idle_addr: got %h %h %h want 0", s_araddr, s_awaddr, s_wdata); end
        idle_inputs();
    endtask

    task automatic test_single_read();
        do_reset();
        m0_arvalid = 1'b1; m0_araddr = 32'h8000_0000; s_arready = 1'b1; m0_rready = 1'b1;
        #1;
        n_cmp++; if (s_arvalid !== 1'b0) begin n_fail++; $display("FAIL sr_bubble: got %b want 0", s_arvalid); end
        step();
        n_cmp++; if ({s_arvalid, m0_arready, s_araddr} !== {2'b11, 32'h8000_0000}) begin n_fail++; $display("FAIL sr_addr: got %b%b %h want 11 80000000", s_arvalid, m0_arready, s_araddr); end
        step();
        m0_arvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_cmp++; if ({m0_rvalid, m1_rvalid, s_arvalid} !== 3'b000) begin n_fail++; $display("FAIL sr_wait: got %b want 000", {m0_rvalid, m1_rvalid, s_arvalid}); end
            step();
        end
        s_rvalid = 1'b1; s_rdata = 32'hDEAD_BEEF; s_rresp = RESP_OKAY;
        #1;
        n_cmp++; if ({m0_rvalid, m1_rvalid, s_rready, m0_rdata} !== {3'b101, 32'hDEAD_BEEF}) begin n_fail++; $display("FAIL sr_data: got %b%b%b %h want 101 deadbeef", m0_rvalid, m1_rvalid, s_rready, m0_rdata); end
        step();
        s_rvalid = 1'b0;
        #1;
        n_cmp++; if ({s_rready, m0_rvalid, m0_rdata} !== 34'h0) begin n_fail++; $display("FAIL sr_done: got %b%b %h want 00 0", s_rready, m0_rvalid, m0_rdata); end
        idle_inputs();
    endtask

    task automatic rr_pair(input logic [31:0] exp0, input logic [31:0] exp1);
        logic [31:0] exp_addr;
        bit found;
        m0_araddr = 32'h100; m1_araddr = 32'h200; m0_arvalid = 1'b1; m1_arvalid = 1'b1;
        s_arready = 1'b1; m0_rready = 1'b1; m1_rready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            exp_addr = (k == 0) ? exp0 : exp1;
            found = 1'b0;
            #1;
            for (int i = 0; i < 8; i++) begin
                if (s_arvalid && s_arready) begin found = 1'b1; break; end
                step();
                #1;
            end
            n_cmp++; if (!found || s_araddr !== exp_addr) begin n_fail++; $display("FAIL rr_order%0d: got %h (seen %0d) want %h", k, s_araddr, found, exp_addr); end
            step();
            if (exp_addr == 32'h100) m0_arvalid = 1'b0; else m1_arvalid = 1'b0;
            s_rvalid = 1'b1; s_rdata = exp_addr + 32'd1;
            #1;
            n_cmp++; if ({m0_rvalid, m1_rvalid} !== ((exp_addr == 32'h100) ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL rr_rvalid%0d: got %b for %h", k, {m0_rvalid, m1_rvalid}, exp_addr); end
            step();
            s_rvalid = 1'b0;
        end
    endtask

    task automatic test_round_robin();
        do_reset();
`ifdef AXI_ARB_FIXED_PRIO_EN
        rr_pair(32'h200, 32'h100);
        rr_pair(32'h200, 32'h100);
`else
        rr_pair(32'h100, 32'h200);
        rr_pair(32'h100, 32'h200);
`endif
        idle_inputs();
    endtask

    task automatic test_split_write();
        do_reset();
        s_awready = 1'b1; s_wready = 1'b1; m1_bready = 1'b1;
        m1_awvalid = 1'b1; m1_awaddr = 32'h1000_0004;
        #1;
        n_cmp++; if (s_awvalid !== 1'b0) begin n_fail++; $display("FAIL sw_bubble: got %b want 0", s_awvalid); end
        step();
        n_cmp++; if ({s_awvalid, m1_awready, s_wvalid, s_awaddr} !== {3'b110, 32'h1000_0004}) begin n_fail++; $display("FAIL sw_aw: got %b%b%b %h want 110 10000004", s_awvalid, m1_awready, s_wvalid, s_awaddr); end
        step();
        m1_awvalid = 1'b0;
        #1;
        n_cmp++; if ({s_awvalid, m1_awready, s_bready, m1_bvalid} !== 4'b0000) begin n_fail++; $display("FAIL sw_awdone: got %b want 0000", {s_awvalid, m1_awready, s_bready, m1_bvalid}); end
        step();
        m1_wvalid = 1'b1; m1_wdata = 32'h1234_5678; m1_wstrb = 4'b0011;
        #1;
        n_cmp++; if ({s_wvalid, m1_wready, s_bready, s_wstrb, s_wdata} !== {3'b110, 4'b0011, 32'h1234_5678}) begin n_fail++; $display("FAIL sw_w: got %b%b%b %b %h want 110 0011 12345678", s_wvalid, m1_wready, s_bready, s_wstrb, s_wdata); end
        step();
        m1_wvalid = 1'b0; s_bvalid = 1'b1; s_bresp = RESP_SLVERR;
        #1;
        n_cmp++; if ({m1_bvalid, m0_bvalid, s_bready, m1_bresp, m0_bresp} !== 7'b1011010) begin n_fail++; $display("FAIL sw_resp: got %b want 1011010", {m1_bvalid, m0_bvalid, s_bready, m1_bresp, m0_bresp}); end
        step();
        s_bvalid = 1'b0;
        #1;
        n_cmp++; if ({s_bready, m1_bvalid, s_wvalid} !== 3'b000) begin n_fail++; $display("FAIL sw_done: got %b want 000", {s_bready, m1_bvalid, s_wvalid}); end
        idle_inputs();
    endtask

    task automatic test_concurrency();
        do_reset();
        s_arready = 1'b1; s_awready = 1'b1; s_wready = 1'b1; m0_rready = 1'b1; m1_bready = 1'b1;
        m0_arvalid = 1'b1; m0_araddr = 32'h40;
        m1_awvalid = 1'b1; m1_awaddr = 32'h80; m1_wvalid = 1'b1; m1_wdata = 32'hCAFE_0001; m1_wstrb = 4'hF;
        step();
        n_cmp++; if ({s_arvalid, s_awvalid, s_wvalid, s_araddr, s_awaddr} !== {3'b111, 32'h40, 32'h80}) begin n_fail++; $display("FAIL cc_addr: got %b%b%b %h %h want 111 40 80", s_arvalid, s_awvalid, s_wvalid, s_araddr, s_awaddr); end
        step();
        m0_arvalid = 1'b0; m1_awvalid = 1'b0; m1_wvalid = 1'b0;
        s_rvalid = 1'b1; s_rdata = 32'h0BAD_F00D; s_rresp = RESP_DECERR; s_bvalid = 1'b1; s_bresp = RESP_OKAY;
        #1;
        n_cmp++; if ({m0_rvalid, m1_bvalid, m1_rvalid, m0_bvalid, m0_rresp, m0_rdata} !== {4'b1100, 2'b11, 32'h0BAD_F00D}) begin n_fail++; $display("FAIL cc_resp: got %b%b%b%b %b %h want 1100 11 0badf00d", m0_rvalid, m1_bvalid, m1_rvalid, m0_bvalid, m0_rresp, m0_rdata); end
        step();
        s_rvalid = 1'b0; s_bvalid = 1'b0;
        #1;
        n_cmp++; if (hs_vec !== 15'h0) begin n_fail++; $display("FAIL cc_done: got %h want 0", hs_vec); end
        idle_inputs();
    endtask

    task automatic test_backpressure();
        do_reset();
        m0_arvalid = 1'b1; m0_araddr = 32'h1234_0000; m0_rready = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if ({s_arvalid, m0_arready, s_rready, s_araddr} !== {3'b100, 32'h1234_0000}) begin n_fail++; $display("FAIL bp_hold%0d: got %b%b%b %h want 100 12340000", i, s_arvalid, m0_arready, s_rready, s_araddr); end
            step();
        end
        s_arready = 1'b1;
        #1;
        n_cmp++; if ({s_arvalid, m0_arready} !== 2'b11) begin n_fail++; $display("FAIL bp_release: got %b want 11", {s_arvalid, m0_arready}); end
        step();
        m0_arvalid = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h7777_0000;
        #1;
        n_cmp++; if ({s_arvalid, m0_rvalid, m0_rdata} !== {2'b01, 32'h7777_0000}) begin n_fail++; $display("FAIL bp_data: got %b%b %h want 01 77770000", s_arvalid, m0_rvalid, m0_rdata); end
        step();
        idle_inputs();
    endtask

    task automatic test_reset_in_rdata();
        bit found;
        do_reset();
        m0_arvalid = 1'b1; m0_araddr = 32'h44; s_arready = 1'b1; m0_rready = 1'b1;
        step();
        step();
        m0_arvalid = 1'b0;
        #1;
        n_cmp++; if ({s_rready, m0_rvalid} !== 2'b10) begin n_fail++; $display("FAIL rr_in_data: got %b want 10", {s_rready, m0_rvalid}); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        n_cmp++; if (hs_vec !== 15'h0) begin n_fail++; $display("FAIL rr_after_rst: got %h want 0", hs_vec); end
        m0_rready = 1'b0;
        m1_arvalid = 1'b1; m1_araddr = 32'h300; m1_rready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (s_arvalid && s_arready) begin found = 1'b1; break; end
            step();
            #1;
        end
        n_cmp++; if (!found || {m1_arready, m0_arready, s_araddr} !== {2'b10, 32'h300}) begin n_fail++; $display("FAIL rr_m1_addr: got %b%b %h (seen %0d) want 10 300", m1_arready, m0_arready, s_araddr, found); end
        step();
        m1_arvalid = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h55AA_55AA; s_rresp = RESP_SLVERR;
        #1;
        n_cmp++; if ({m1_rvalid, m0_rvalid, m1_rresp, m1_rdata} !== {4'b1010, 32'h55AA_55AA}) begin n_fail++; $display("FAIL rr_m1_data: got %b%b %b %h want 10 10 55aa55aa", m1_rvalid, m0_rvalid, m1_rresp, m1_rdata); end
        step();
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single_read();
        test_round_robin();
        test_split_write();
        test_concurrency();
        test_backpressure();
        test_reset_in_rdata();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_lite_arb2.md
Name: axi_lite_arb2

Overview:
Two-master to one-slave AXI4-Lite arbiter placed between the core's requesters and AXI_Interconnect. Master 0 is instruction fetch; master 1 is load/store. Read and write channels are arbitrated independently, each with one outstanding transaction. The default policy is round-robin.

Parameters:
ADDR_W, 32, address width of all AR/AW channels
DATA_W, 32, data width; strobe width is DATA_W/8

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
mN_araddr in ADDR_W / mN_arvalid in 1 / mN_arready out 1 (N=0,1)  upstream read address
mN_rdata out DATA_W / mN_rresp out 2 / mN_rvalid out 1 / mN_rready in 1 (N=0,1)  upstream read data
mN_awaddr in ADDR_W / mN_awvalid in 1 / mN_awready out 1 (N=0,1)  upstream write address
mN_wdata in DATA_W / mN_wstrb in DATA_W/8 / mN_wvalid in 1 / mN_wready out 1 (N=0,1)  upstream write data
mN_bresp out 2 / mN_bvalid out 1 / mN_bready in 1 (N=0,1)  upstream write response
s_araddr out / s_arvalid out / s_arready in; s_rdata in / s_rresp in / s_rvalid in / s_rready out  downstream read
s_awaddr out / s_awvalid out / s_awready in; s_wdata out / s_wstrb out / s_wvalid out / s_wready in; s_bresp in / s_bvalid in / s_bready out  downstream write

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - Read and write FSMs go to IDLE.
  - All valid and ready outputs are 0.
  - Both round-robin pointers are set so m0 wins the first tie.
  - Address, data, strobe and response outputs are 0 in IDLE.
- Read FSM, states R_IDLE, R_ADDR, R_DATA:
  - R_IDLE: if any mN_arvalid is high, register grant g and go to R_ADDR. No upstream ready is asserted in R_IDLE.
  - R_ADDR: s_araddr=m[g]_araddr, s_arvalid=m[g]_arvalid, m[g]_arready=s_arready. The other master's arready is 0. On s_arvalid&s_arready, go to R_DATA.
  - R_DATA: rdata/rresp are broadcast to both masters. m[g]_rvalid=s_rvalid; the other master's rvalid is 0. s_rready=m[g]_rready. On handshake, go to R_IDLE and set the read pointer to g.
- Write FSM, states W_IDLE, W_ADDR, W_RESP:
  - W_IDLE: grant is triggered by mN_awvalid only.
  - W_ADDR: AW and W are forwarded independently. aw_done and w_done latch their respective handshakes. s_awvalid=m[g]_awvalid&~aw_done and s_wvalid=m[g]_wvalid&~w_done. Go to W_RESP when both handshakes are done, including the same cycle or W before AW. Clear both flags on exit.
  - W_RESP: bresp is broadcast. m[g]_bvalid=s_bvalid and s_bready=m[g]_bready. On handshake, go to W_IDLE and set the write pointer to g.
- Arbitration:
  - Single requester: that requester wins.
  - Both requesting: the master not equal to the channel's pointer wins.
  - Grant is held until the transaction completes; there is no preemption.
- Latency: one-cycle arbitration bubble. Request at cycle 0 gives s_*valid at cycle 1 at the earliest; the slave-to-master response path is combinational.
- Channel independence: a read and a write may proceed concurrently, from the same or different masters.
- Response passthrough: responses are passed unmodified, including SLVERR/DECERR.
- Reset mid-transaction: next cycle is IDLE with all valids/readys at 0. The downstream transaction is abandoned; the interconnect is reset by the same rst.

Optional Feature:
AXI_ARB_FIXED_PRIO_EN
- Defined: m1 (load/store) always wins simultaneous requests on both channels, and the pointers are unused.
- Undefined: round-robin as described above.
- FSMs and latency are identical in both cases.

Decomposition:
- Package axi_lite_pkg:
  - ADDR_W/DATA_W defaults.
  - RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - Read and write FSM state encodings.
- Sub-module rr_arb2: 2-way grant with pointer input and priority-mode option. It is instantiated once for read and once for write.

Test Plan:
- Single read: m0 reads 0x8000_0000, slave returns 0xDEADBEEF OKAY after 2 cycles. Expect s_arvalid 1 cycle after m0_arvalid, m0_rdata=0xDEADBEEF with m0_rvalid, and m1_rvalid=0 throughout.
- Round-robin: after reset, m0 (0x100) and m1 (0x200) assert arvalid together. Expect order 0x100, 0x200; then both again: 0x100, 0x200. With AXI_ARB_FIXED_PRIO_EN, order is 0x200, 0x100 both times.
- Split write: m1 AW 0x1000_0004 at cycle 0, W 0x1234_5678 strb 4'b0011 at cycle 3. Expect the slave to see the exact addr/data/strb, and m1_bvalid only after both handshakes.
- Concurrency: m0 read 0x40 and m1 write 0x80 in the same cycle. Both complete, with no stall of either channel caused by the other.
- Backpressure: s_arready held 0 for 5 cycles. Expect s_araddr stable, m0_arready=0, and no state change until the handshake.
- Reset in R_DATA: assert rst for 1 cycle while s_rvalid=0. Next cycle all valid/ready outputs are 0; a subsequent m1 read at 0x300 completes normally.
